// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, alu_result_stage and its consumer.
// ALU_RESULT_STAGE_PARITY_EN adds the out_parity signal.
interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_c_out;
  logic             in_a_msb;
  logic             in_b_msb;
  logic [2:0]       in_aluop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             sticky_v;
  logic             sticky_clr;
`ifdef ALU_RESULT_STAGE_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_valid, in_result, in_c_out, in_a_msb, in_b_msb, in_aluop,
    output out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_flags, sticky_v
`ifdef ALU_RESULT_STAGE_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_result, in_c_out, in_a_msb, in_b_msb, in_aluop,
    input  out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_flags, sticky_v
`ifdef ALU_RESULT_STAGE_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result/flag register with a 2-entry skid buffer: latency 1, in_ready driven from a flop,
// back-pressure parks one entry in the skid register. ALU_RESULT_STAGE_PARITY_EN adds out_parity.
module alu_result_stage #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] ADD_OP = 3'b010,
  parameter logic [2:0] SUB_OP = 3'b110
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     new_entry;
  logic       in_ready_q;
  logic       sticky_q, sticky_d;
  logic       is_add, is_sub, r_msb, v_flag;
  logic       accept, xfer;

  // Flags are frozen with the entry at acceptance, so a stalled entry keeps its own flags.
  always_comb begin
    new_entry        = '0;
    is_add           = (bus.in_aluop == ADD_OP);
    is_sub           = (bus.in_aluop == SUB_OP);
    r_msb            = bus.in_result[WIDTH-1];
    v_flag           = (is_add & (bus.in_a_msb == bus.in_b_msb) & (r_msb != bus.in_a_msb)) |
                       (is_sub & (bus.in_a_msb != bus.in_b_msb) & (r_msb != bus.in_a_msb));
    new_entry.result = bus.in_result;
    new_entry.flags  = {r_msb, (bus.in_result == '0), (is_add | is_sub) & bus.in_c_out, v_flag};
`ifdef ALU_RESULT_STAGE_PARITY_EN
    new_entry.parity = ^bus.in_result;
`endif
  end

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Set has priority over a same-cycle clear.
  assign sticky_d = (accept & new_entry.flags[0]) | (sticky_q & ~bus.sticky_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
      sticky_q   <= sticky_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_result = main_q.result;
  assign bus.out_flags  = main_q.flags;
  assign bus.sticky_v   = sticky_q;
`ifdef ALU_RESULT_STAGE_PARITY_EN
  assign bus.out_parity = main_q.parity;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed cases with literal expectations plus a randomized run
// checked every cycle against a queue-based model.
module tb_alu_result_stage;
  localparam int         W   = 16;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_result_stage_if #(.WIDTH(W)) bus();

  alu_result_stage #(.WIDTH(W), .ADD_OP(ADD), .SUB_OP(SUB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t        q[$];
  logic        m_sticky = 1'b0;
  logic        m_xfer, m_acc;
  logic [3:0]  m_flags;
  logic [15:0] op_a, op_b;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] corners[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags from signed integer arithmetic: V means the true sum/difference left the 16-bit range.
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] r, input logic c);
    int   sa = $signed(a);
    int   sb = $signed(b);
    int   s  = 0;
    logic arith = (op == ADD) || (op == SUB);
    if (op == ADD) s = sa + sb;
    else if (op == SUB) s = sa - sb;
    return {r[15], r == 16'h0000, arith ? c : 1'b0, arith && (s > 32767 || s < -32768)};
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    op_a = a;
    op_b = b;
    if (op == ADD)      s = {1'b0, a} + {1'b0, b};
    else if (op == SUB) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else                s = {1'($urandom), a & b};
    bus.in_aluop  = op;
    bus.in_a_msb  = a[15];
    bus.in_b_msb  = b[15];
    bus.in_result = s[15:0];
    bus.in_c_out  = s[16];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_sticky = 1'b0;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_sticky_v", bus.sticky_v, 1'b0);
      chk("rst_out_result", bus.out_result, 16'h0000);
      chk("rst_out_flags", bus.out_flags, 4'h0);
`ifdef ALU_RESULT_STAGE_PARITY_EN
      chk("rst_out_parity", bus.out_parity, 1'b0);
`endif
    end else begin
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("in_ready", bus.in_ready, q.size() != 2);
      chk("sticky_v", bus.sticky_v, m_sticky);
      if (q.size() != 0) begin
        chk("out_result", bus.out_result, q[0].res);
        chk("out_flags", bus.out_flags, q[0].flags);
`ifdef ALU_RESULT_STAGE_PARITY_EN
        chk("out_parity", bus.out_parity, ^q[0].res);
`endif
      end
      m_xfer   = (q.size() != 0) && bus.out_ready;
      m_acc    = bus.in_valid && (q.size() < 2);
      m_flags  = ref_flags(bus.in_aluop, op_a, op_b, bus.in_result, bus.in_c_out);
      m_sticky = (m_acc && m_flags[0]) || (m_sticky && !bus.sticky_clr);
      if (m_xfer) void'(q.pop_front());
      if (m_acc) q.push_back('{bus.in_result, m_flags});
    end
  end

  initial begin
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b0;
    set_op(ADD, 16'h0000, 16'h0000);
    repeat (2) tick();
    chk("lit_reset_in_ready", bus.in_ready, 1'b1);
    chk("lit_reset_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // Zero result with carry out, no overflow.
    set_op(ADD, 16'hFFFF, 16'h0001);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("lit_zero_valid", bus.out_valid, 1'b1);
    chk("lit_zero_flags", bus.out_flags, 4'b0110);
    chk("lit_zero_result", bus.out_result, 16'h0000);

    // Signed overflow on add, then sticky clear.
    set_op(ADD, 16'h7FFF, 16'h0001);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("lit_ovf_flags", bus.out_flags, 4'b1001);
    chk("lit_ovf_result", bus.out_result, 16'h8000);
    chk("lit_ovf_sticky", bus.sticky_v, 1'b1);
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    chk("lit_sticky_clr", bus.sticky_v, 1'b0);

    // Subtract overflow, then the same operands under a non-arithmetic op.
    set_op(SUB, 16'h8000, 16'h0001);
    bus.in_valid = 1'b1;
    tick();
    chk("lit_sub_flags", bus.out_flags, 4'b0011);
    chk("lit_sub_result", bus.out_result, 16'h7FFF);
    bus.in_aluop = 3'b000;
    tick();
    bus.in_valid = 1'b0;
    chk("lit_logic_flags", bus.out_flags, 4'b0000);
    tick();

    // Back-pressure: fill both entries, hold the third, then drain in order.
    bus.out_ready = 1'b0;
    set_op(ADD, 16'h0000, 16'h0001);
    bus.in_valid = 1'b1;
    tick();
    chk("lit_bp_ready1", bus.in_ready, 1'b1);
    set_op(ADD, 16'h0000, 16'h0002);
    tick();
    chk("lit_bp_ready2", bus.in_ready, 1'b0);
    chk("lit_bp_head", bus.out_result, 16'h0001);
    set_op(ADD, 16'h0000, 16'h0003);
    repeat (2) tick();
    chk("lit_bp_hold", bus.out_result, 16'h0001);
    chk("lit_bp_still_full", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("lit_bp_second", bus.out_result, 16'h0002);
    chk("lit_bp_reopen", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("lit_bp_third", bus.out_result, 16'h0003);
    tick();
    chk("lit_bp_drained", bus.out_valid, 1'b0);

    // Streaming at one result per cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(ADD, 16'($urandom), 16'($urandom));
      tick();
      chk("lit_stream_ready", bus.in_ready, 1'b1);
      chk("lit_stream_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick();

    // Reset while both entries are occupied.
    bus.out_ready = 1'b0;
    set_op(ADD, 16'h7FFF, 16'h0001);
    bus.in_valid = 1'b1;
    tick();
    set_op(ADD, 16'h0000, 16'h0005);
    tick();
    bus.in_valid = 1'b0;
    chk("lit_two_in_ready", bus.in_ready, 1'b0);
    chk("lit_two_sticky", bus.sticky_v, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("lit_arst_out_valid", bus.out_valid, 1'b0);
    chk("lit_arst_in_ready", bus.in_ready, 1'b1);
    chk("lit_arst_sticky", bus.sticky_v, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      int          k;
      k = $urandom_range(0, 4);
      if (k < 2)       op = ADD;
      else if (k < 4)  op = SUB;
      else begin
        op = 3'($urandom_range(0, 7));
        if (op == ADD || op == SUB) op = 3'b000;
      end
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = corners[$urandom_range(0, 4)];
        1:       b = (op == SUB) ? a : 16'(-a);
        default: b = 16'($urandom);
      endcase
      set_op(op, a, b);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.sticky_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
